// File: rtl/cfg_scan_chain.sv
// Serial configuration scan chain with a shadow register: write shifts bits in, then updates cfg_q.
// Readback captures parallel data, then shifts it out. A shift only happens on cycles with sin_valid high.
module cfg_scan_chain #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic [WIDTH-1:0] cap_d,
  output logic             sout,
  output logic             sout_valid,
  output logic [WIDTH-1:0] cfg_q,
  output logic [WIDTH-1:0] cfg_qb,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_mode;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_chain;
  logic [WIDTH-1:0] r_cfg;
  logic             r_busy;
  logic             r_done;
  logic             w_shift;

  assign w_shift = (r_state == S_SHIFT) && sin_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_chain <= RESET_VAL;
      r_cfg   <= RESET_VAL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= mode ? S_CAPTURE : S_SHIFT;
          end
        end
        S_CAPTURE: begin
          r_chain <= cap_d;
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_shift) begin
            r_chain <= {sin, r_chain[WIDTH-1:1]};
            // Counter wraps to 0 on the last shift so it never exceeds WIDTH-1.
            if (r_cnt == LAST) begin
              r_cnt <= '0;
              if (r_mode) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_UPDATE;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_UPDATE: begin
          r_cfg   <= r_chain;
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sout       = r_chain[0];
  assign sout_valid = w_shift;
  assign cfg_q      = r_cfg;
  assign cfg_qb     = ~r_cfg;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_cfg_scan_chain.sv
// Bench for cfg_scan_chain: WIDTH=8 table of write/readback operations with a done/sout scoreboard,
// plus abort and ignored-start sequences, and WIDTH=2 / WIDTH=1024 all-ones writes.
module tb_cfg_scan_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       start, mode, sin, sin_valid;
  logic [7:0] cap_d, cfg_q, cfg_qb;
  logic       sout, sout_valid, busy, done;

  logic       s_start, s_sin, s_sin_valid;
  logic [1:0] s_cap, s_cfg, s_cfgb;
  logic       s_sout, s_soutv, s_busy, s_done;

  logic          l_start, l_sin, l_sin_valid;
  logic [1023:0] l_cap, l_cfg, l_cfgb;
  logic          l_sout, l_soutv, l_busy, l_done;

  cfg_scan_chain #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .sin(sin), .sin_valid(sin_valid),
    .cap_d(cap_d), .sout(sout), .sout_valid(sout_valid), .cfg_q(cfg_q), .cfg_qb(cfg_qb),
    .busy(busy), .done(done)
  );

  cfg_scan_chain #(.WIDTH(2), .RESET_VAL(2'b10)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .mode(1'b0), .sin(s_sin), .sin_valid(s_sin_valid),
    .cap_d(s_cap), .sout(s_sout), .sout_valid(s_soutv), .cfg_q(s_cfg), .cfg_qb(s_cfgb),
    .busy(s_busy), .done(s_done)
  );

  cfg_scan_chain #(.WIDTH(1024)) dut_l (
    .clk(clk), .reset(reset), .start(l_start), .mode(1'b0), .sin(l_sin), .sin_valid(l_sin_valid),
    .cap_d(l_cap), .sout(l_sout), .sout_valid(l_soutv), .cfg_q(l_cfg), .cfg_qb(l_cfgb),
    .busy(l_busy), .done(l_done)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic mon_en = 1'b0;
  logic rb_active = 1'b0;
  logic [7:0] exp_cfg_q[$];
  logic       exp_sout_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: done pops the expected cfg_q; readback sout bits are popped on each sout_valid.
  logic [7:0] m_exp, m_inv, m_cfginv;
  always @(negedge clk) begin
    if (mon_en) begin
      m_cfginv = ~cfg_q;
      chk("cfg_qb_inverse", cfg_qb, m_cfginv);
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_cfg_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation");
        end else begin
          m_exp = exp_cfg_q.pop_front();
          m_inv = ~m_exp;
          chk("done_cfg_q", cfg_q, m_exp);
          chk("done_cfg_qb", cfg_qb, m_inv);
        end
      end
      if (sout_valid === 1'b1 && rb_active) begin
        if (exp_sout_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_sout: got sout_valid=1 expected no more readback bits");
        end else begin
          chk("readback_sout", sout, exp_sout_q.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic       md;
    logic [7:0] dat;
    logic       stall;
    logic       glitch;
    logic [7:0] exp_cfg;
    int         exp_lat;
  } vec_t;

  task automatic run_op(input logic md, input logic [7:0] dat, input logic stall,
                        input logic glitch, input logic [7:0] expc, output int lat);
    int   shifts;
    int   first;
    logic ph;
    logic seen;
    logic in_sh;
    shifts = 0;
    ph     = 1'b0;
    seen   = 1'b0;
    lat    = -1;
    first  = md ? 2 : 1;
    rb_active = md;
    if (md) for (int k = 0; k < 8; k++) exp_sout_q.push_back(dat[k]);
    exp_cfg_q.push_back(expc);
    cap_d = md ? dat : 8'h00;
    start = 1'b1; mode = md; sin_valid = 1'b0; sin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 100 && !seen; e++) begin
      in_sh = (e >= first) && (shifts < 8);
      sin_valid = in_sh ? (stall ? ph : 1'b1) : 1'b0;
      if (in_sh && stall) ph = ~ph;
      sin = in_sh ? (md ? ~dat[shifts] : dat[shifts]) : 1'b0;
      start = glitch && (e == first + 2);
      #1;
      chk("sout_valid", sout_valid, in_sh && sin_valid);
      if (in_sh && sin_valid) shifts++;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = e;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: got no done within 100 cycles expected done");
    end
    sin_valid = 1'b0;
    start = glitch;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_done", busy, 1'b0);
    chk("done_one_cycle", done, 1'b0);
    @(posedge clk); #1;
    chk("start_in_done_ignored", busy, 1'b0);
    rb_active = 1'b0;
  endtask

  initial begin
    vec_t tbl[7];
    int   lat;
    int   n_ops;
    int   s_lat, l_lat;
    logic [1:0] s_inv;

    tbl[0] = '{1'b0, 8'h4D, 1'b0, 1'b0, 8'h4D, 9};
    tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h4D, 9};
    tbl[2] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 9};
    tbl[3] = '{1'b0, 8'h4D, 1'b1, 1'b0, 8'h4D, 17};
    tbl[4] = '{1'b1, 8'h96, 1'b0, 1'b0, 8'h4D, 9};
    tbl[5] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 9};
    tbl[6] = '{1'b1, 8'h5A, 1'b1, 1'b1, 8'hFF, 17};

    reset = 1'b1;
    start = 1'b0; mode = 1'b0; sin = 1'b0; sin_valid = 1'b1; cap_d = 8'h00;
    s_start = 1'b0; s_sin = 1'b0; s_sin_valid = 1'b1; s_cap = 2'b00;
    l_start = 1'b0; l_sin = 1'b0; l_sin_valid = 1'b0; l_cap = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sout", sout, 1'b0);
    chk("rst_sout_valid", sout_valid, 1'b0);
    chk("rst_cfg_q", cfg_q, 8'h00);
    chk("rst_cfg_qb", cfg_qb, 8'hFF);
    chk("rst_w2_cfg_q", s_cfg, 2'b10);
    chk("rst_w2_cfg_qb", s_cfgb, 2'b01);
    chk("rst_w2_sout", s_sout, 1'b0);
    chk("rst_w2_sout_valid", s_soutv, 1'b0);
    sin_valid = 1'b0;
    s_sin_valid = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    n_ops = 0;
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].md, tbl[i].dat, tbl[i].stall, tbl[i].glitch, tbl[i].exp_cfg, lat);
      n_ops++;
      chk($sformatf("latency_vec%0d", i), lat, tbl[i].exp_lat);
    end

    // Reset after four shifts of a write aborts it with no done pulse.
    start = 1'b1; mode = 1'b0; sin = 1'b1; sin_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("abort_busy_mid", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sin_valid = 1'b0;
    chk("abort_cfg_q", cfg_q, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sout_valid", sout_valid, 1'b0);
    @(posedge clk); #1;
    chk("abort_no_done_late", done, 1'b0);

    // Reset dominates a simultaneous start.
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("reset_beats_start", busy, 1'b0);
    @(posedge clk); #1;
    chk("reset_beats_start_late", busy, 1'b0);

    run_op(1'b0, 8'h4D, 1'b0, 1'b0, 8'h4D, lat);
    n_ops++;
    chk("post_abort_latency", lat, 9);

    repeat (2) @(posedge clk);
    #1;
    chk("done_count", done_cnt, n_ops);
    chk("cfg_queue_drained", exp_cfg_q.size(), 0);
    chk("sout_queue_drained", exp_sout_q.size(), 0);

    // WIDTH=2 and WIDTH=1024: all-ones write with continuous sin_valid.
    s_start = 1'b1; l_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; l_start = 1'b0;
    s_sin = 1'b1; s_sin_valid = 1'b1;
    l_sin = 1'b1; l_sin_valid = 1'b1;
    s_lat = -1; l_lat = -1;
    for (int e = 1; e <= 1100 && l_lat < 0; e++) begin
      @(posedge clk); #1;
      if (s_done === 1'b1 && s_lat < 0) begin
        s_lat = e;
        s_inv = ~s_cfg;
        chk("w2_cfg_q", s_cfg, 2'b11);
        chk("w2_cfg_qb", s_cfgb, s_inv);
      end
      if (l_done === 1'b1) begin
        l_lat = e;
        chk("w1024_cfg_all_ones", &l_cfg, 1'b1);
        chk("w1024_cfg_qb_zero", |l_cfgb, 1'b0);
      end
    end
    s_sin_valid = 1'b0; l_sin_valid = 1'b0;
    chk("w2_latency", s_lat, 3);
    chk("w1024_latency", l_lat, 1025);
    repeat (2) @(posedge clk);
    #1;
    chk("w2_idle", s_busy, 1'b0);
    chk("w1024_idle", l_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
